fir_multichannel: RTL and testbench
===================================

FIR_MULTICHANNEL -- requirements
Module: fir_multichannel

Interface
REQ-001 Parameter DATA_W, 8: unsigned input sample width.
REQ-002 Parameter COEF_W, 8: unsigned coefficient width.
REQ-003 Parameter TAPS, 16: filter length, power of two, 2 to 64.
REQ-004 Parameter CH, 2: independent channel count, 1 to 8; CH_W = max(1, clog2(CH)).
REQ-005 Derived OUT_W = DATA_W + COEF_W + clog2(TAPS); defaults give 20.
REQ-006 CLK_Filter  in  1  sole clock; all state updates on the rising edge.
REQ-007 rst_n  in  1  synchronous, active-low reset.
REQ-008 In_Valid  in  1  sample offered.
REQ-009 In_Ready  out  1  block can accept a sample.
REQ-010 In_Channel  in  CH_W  channel of the offered sample.
REQ-011 In_Sample  in  DATA_W  unsigned ADC sample.
REQ-012 Coef_WE  in  1  coefficient write strobe.
REQ-013 Coef_Addr  in  clog2(TAPS)  tap index to write.
REQ-014 Coef_Data  in  COEF_W  coefficient value.
REQ-015 Out_Valid  out  1  one-cycle result strobe.
REQ-016 Out_Channel  out  CH_W  channel of the result.
REQ-017 Out_Filtered  out  OUT_W  unsigned filter result.

Function
REQ-018 The block SHALL hold one TAPS-deep circular sample history per channel and one coefficient bank shared by all channels.
REQ-019 FSM states SHALL be IDLE, MAC, DONE; In_Ready SHALL be 1 only in IDLE.
REQ-020 Handshake: a sample is accepted on a cycle with In_Valid=1 and In_Ready=1; the sample is written to the channel's history at the newest position and the FSM SHALL go IDLE->MAC.
REQ-021 MAC SHALL last exactly TAPS cycles, computing y = sum over k=0..TAPS-1 of coef[k] * x[n-k] for the accepted channel, using one multiplier.
REQ-022 MAC->DONE SHALL occur after the last tap; in DONE, Out_Filtered and Out_Channel SHALL be registered, Out_Valid=1 for one cycle, and the FSM SHALL return to IDLE.
REQ-023 Latency: Out_Valid SHALL assert exactly TAPS+1 cycles after the accept edge (17 for defaults); sustained throughput is one sample per TAPS+2 cycles.
REQ-024 Out_Filtered and Out_Channel SHALL hold their values until the next DONE.
REQ-025 Accumulation SHALL be at full OUT_W width with no truncation; overflow is impossible by construction.
REQ-026 History entries not yet written since reset SHALL read as 0.
REQ-027 A sample with In_Channel >= CH SHALL be accepted and discarded: no history write, no FSM transition, no Out_Valid.
REQ-028 Coef_WE SHALL take effect only in IDLE and SHALL be ignored in MAC and DONE.
REQ-029 Coef_WE and an accepted sample on the same IDLE cycle SHALL both take effect, and that sample's MAC SHALL use the new coefficient.
REQ-030 In_Valid, In_Channel, and In_Sample SHALL be ignored outside IDLE.

Reset
REQ-031 With rst_n=0 at a clock edge, the FSM SHALL enter IDLE, all histories SHALL clear to 0, and all coefficients SHALL load 1.
REQ-032 Reset values: Out_Valid=0, Out_Filtered=0, Out_Channel=0; In_Ready=1 on the first cycle after reset release.
REQ-033 Reset during MAC or DONE SHALL abort the computation with no Out_Valid.

Configuration
REQ-034 With macro FIR_BYPASS_EN defined, an extra input port Bypass (1 bit) SHALL exist.
REQ-035 Bypass behaviour when Bypass=1: an accepted sample SHALL go IDLE->DONE, Out_Filtered = the zero-extended sample, Out_Valid one cycle after accept, and history SHALL still be updated.
REQ-036 Without FIR_BYPASS_EN, the Bypass port and its logic SHALL be absent and behaviour SHALL match Bypass=0.

Verification
REQ-037 Reset, then ch0 sample 200 -> Out_Valid 17 cycles after accept, Out_Filtered=200, Out_Channel=0.
REQ-038 Sixteen ch0 samples of 200, then sixteen of 100 -> 16th result 3200; 32nd result 1600.
REQ-039 Alternate ch0=200 and ch1=100 -> first ch1 result 100; second ch0 result 400 (channels independent).
REQ-040 Write coef[0]=255, others 0, then sample 255 -> 65025; then all coef=255 with 16 samples of 255 -> 1040400 (< 2^20).
REQ-041 rst_n=0 mid-MAC -> no Out_Valid and outputs 0; next sample 100 -> result 100 (history and coefficients restored).
REQ-042 FIR_BYPASS_EN defined, Bypass=1, sample 77 -> Out_Filtered=77 one cycle after accept; then Bypass=0, sample 0 -> result 77.

Source files
------------

// File: rtl/fir_multichannel.sv
// ---------------------------------------------------------------------------
// fir_multichannel
//   Time-multiplexed FIR filter for up to 8 channels. Each channel keeps its
//   own circular history of TAPS samples. All channels share one coefficient
//   bank and one multiplier. An accepted sample starts a TAPS-cycle serial
//   MAC. The result is registered in DONE and strobed on Out_Valid.
//
//   Optional feature: define FIR_BYPASS_EN to add the Bypass input. While
//   Bypass=1, an accepted sample skips the MAC and is returned zero-extended.
//   The history is still updated.
//
// Ports
//   CLK_Filter    : clock, rising edge
//   rst_n         : synchronous active-low reset
//   In_Valid      : sample offered
//   In_Ready      : high only in IDLE
//   In_Channel    : channel of the offered sample (>= CH: accepted, dropped)
//   In_Sample     : unsigned sample
//   Coef_WE       : coefficient write strobe, honoured only in IDLE
//   Coef_Addr     : tap index to write
//   Coef_Data     : coefficient value
//   Out_Valid     : one-cycle result strobe
//   Out_Channel   : channel of the result
//   Out_Filtered  : full-width unsigned result, held until the next result
//   Bypass        : (FIR_BYPASS_EN only) return the sample unfiltered
// ---------------------------------------------------------------------------
module fir_multichannel #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 16,
  parameter int CH     = 2,
  localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1,
  localparam int AW    = $clog2(TAPS),
  localparam int OUT_W = DATA_W + COEF_W + AW
) (
  input  logic              CLK_Filter,
  input  logic              rst_n,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [CH_W-1:0]   In_Channel,
  input  logic [DATA_W-1:0] In_Sample,
  input  logic              Coef_WE,
  input  logic [AW-1:0]     Coef_Addr,
  input  logic [COEF_W-1:0] Coef_Data,
`ifdef FIR_BYPASS_EN
  input  logic              Bypass,
`endif
  output logic              Out_Valid,
  output logic [CH_W-1:0]   Out_Channel,
  output logic [OUT_W-1:0]  Out_Filtered
);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t state, state_n;

  logic [DATA_W-1:0]        hist [CH][TAPS];
  logic [AW-1:0]            wr_ptr [CH];
  logic [COEF_W-1:0]        coef [TAPS];

  logic [CH_W-1:0]          cur_ch;
  logic [AW-1:0]            cur_ptr;
  logic [AW-1:0]            tap_cnt;
  logic [AW-1:0]            rd_idx;
  logic [OUT_W-1:0]         acc;
  logic [DATA_W+COEF_W-1:0] prod;

  logic ch_ok;
  logic start;
  logic last_tap;
  logic bypass_sel;

`ifdef FIR_BYPASS_EN
  assign bypass_sel = Bypass;
`else
  assign bypass_sel = 1'b0;
`endif

  // The channel is widened by one bit so that the compare stays meaningful
  // when CH is a power of two.
  assign ch_ok    = ({1'b0, In_Channel} < (CH_W + 1)'(CH));
  // A sample on an out-of-range channel is still accepted (In_Ready is
  // high), but it does not start a computation.
  assign start    = (state == IDLE) && In_Valid && ch_ok;
  assign last_tap = (tap_cnt == AW'(TAPS - 1));

  // cur_ptr holds the newest sample. Tap k reads k positions back; the
  // subtraction wraps modulo TAPS.
  assign rd_idx = cur_ptr - tap_cnt;
  assign prod   = (DATA_W + COEF_W)'(coef[tap_cnt]) *
                  (DATA_W + COEF_W)'(hist[cur_ch][rd_idx]);

  always_ff @(posedge CLK_Filter) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    In_Ready = 1'b0;
    unique case (state)
      IDLE: begin
        In_Ready = 1'b1;
        if (start) state_n = bypass_sel ? DONE : MAC;
      end
      MAC:     if (last_tap) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK_Filter) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < CH; c++) begin
        wr_ptr[c] <= '0;
        for (int unsigned t = 0; t < TAPS; t++) hist[c][t] <= '0;
      end
      for (int unsigned t = 0; t < TAPS; t++) coef[t] <= COEF_W'(1);
      cur_ch       <= '0;
      cur_ptr      <= '0;
      tap_cnt      <= '0;
      acc          <= '0;
      Out_Valid    <= 1'b0;
      Out_Filtered <= '0;
      Out_Channel  <= '0;
    end else begin
      Out_Valid <= 1'b0;

      // The coefficient write lands on the accept edge, so the MAC that
      // starts on that edge already sees the new value.
      if (state == IDLE && Coef_WE) coef[Coef_Addr] <= Coef_Data;

      if (start) begin
        hist[In_Channel][wr_ptr[In_Channel]] <= In_Sample;
        wr_ptr[In_Channel] <= wr_ptr[In_Channel] + AW'(1);
        cur_ch  <= In_Channel;
        cur_ptr <= wr_ptr[In_Channel];
        tap_cnt <= '0;
        acc     <= bypass_sel ? OUT_W'(In_Sample) : '0;
      end

      if (state == MAC) begin
        acc     <= acc + OUT_W'(prod);
        tap_cnt <= tap_cnt + AW'(1);
      end

      if (state == DONE) begin
        Out_Valid    <= 1'b1;
        Out_Filtered <= acc;
        Out_Channel  <= cur_ch;
      end
    end
  end

endmodule

// File: tb/tb_fir_multichannel.sv
// ---------------------------------------------------------------------------
// tb_fir_multichannel
//   Scoreboard bench for fir_multichannel with TAPS=16 and CH=3.
//   Channel 3 exercises the out-of-range drop path.
//   The driver tasks update a shift-register reference model on each accept
//   edge and queue the expected result. The expected result carries the
//   value, the channel and the due time. An independent monitor compares
//   every Out_Valid pulse against the head of the queue.
// ---------------------------------------------------------------------------
module tb_fir_multichannel;

  localparam int TAPS = 16;
  localparam int NCH  = 3;
  localparam int P    = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        In_Valid = 1'b0;
  logic        In_Ready;
  logic [1:0]  In_Channel = '0;
  logic [7:0]  In_Sample = '0;
  logic        Coef_WE = 1'b0;
  logic [3:0]  Coef_Addr = '0;
  logic [7:0]  Coef_Data = '0;
  logic        bypass = 1'b0;
  logic        Out_Valid;
  logic [1:0]  Out_Channel;
  logic [19:0] Out_Filtered;

  always #(P/2) clk = ~clk;

  fir_multichannel #(.DATA_W(8), .COEF_W(8), .TAPS(TAPS), .CH(NCH)) dut (
    .CLK_Filter  (clk),
    .rst_n       (rst_n),
    .In_Valid    (In_Valid),
    .In_Ready    (In_Ready),
    .In_Channel  (In_Channel),
    .In_Sample   (In_Sample),
    .Coef_WE     (Coef_WE),
    .Coef_Addr   (Coef_Addr),
    .Coef_Data   (Coef_Data),
`ifdef FIR_BYPASS_EN
    .Bypass      (bypass),
`endif
    .Out_Valid   (Out_Valid),
    .Out_Channel (Out_Channel),
    .Out_Filtered(Out_Filtered)
  );

  typedef struct {
    int unsigned val;
    int unsigned ch;
    longint      t;
    int unsigned lat;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned m_hist [NCH][TAPS];
  int unsigned m_coef [TAPS];
  longint      prev_acc_t = 0;
  longint      last_acc_t = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < TAPS; k++) m_hist[c][k] = 0;
    for (int k = 0; k < TAPS; k++) m_coef[k] = 1;
  endfunction

  // m_hist[c][k] holds x[n-k] for channel c. A new sample shifts the
  // older entries one place down.
  function automatic void model_accept(input int unsigned ch, input int unsigned s,
                                       input bit byp, input longint t);
    exp_t e;
    int unsigned y = 0;
    if (ch >= NCH) return;
    for (int k = TAPS - 1; k > 0; k--) m_hist[ch][k] = m_hist[ch][k-1];
    m_hist[ch][0] = s;
    for (int k = 0; k < TAPS; k++) y += m_coef[k] * m_hist[ch][k];
    e.val = byp ? s : y;
    e.ch  = ch;
    e.t   = t;
    e.lat = byp ? 1 : TAPS + 1;
    exp_q.push_back(e);
  endfunction

  // Monitor: it samples on the falling edge. Out_Valid becomes visible
  // after an active edge, so the expected offset from the accept edge is
  // lat*P + P/2.
  always @(negedge clk) begin
    if (rst_n && Out_Valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got value %0d ch %0d, none expected at %0t",
                 Out_Filtered, Out_Channel, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", Out_Filtered, e.val);
        check("out_channel", Out_Channel, e.ch);
        check("latency", $time - e.t, e.lat * P + P / 2);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!In_Ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!In_Ready) check("ready_timeout", 0, 1);
  endtask

  task automatic send(input int unsigned ch, input int unsigned s,
                      input bit we = 0, input int unsigned addr = 0,
                      input int unsigned data = 0);
    wait_ready();
    In_Valid   = 1'b1;
    In_Channel = 2'(ch);
    In_Sample  = 8'(s);
    Coef_WE    = we;
    Coef_Addr  = 4'(addr);
    Coef_Data  = 8'(data);
    @(posedge clk);
    if (we) m_coef[addr] = data;
    prev_acc_t = last_acc_t;
    last_acc_t = $time;
    model_accept(ch, s, bypass, $time);
    #1;
    In_Valid = 1'b0;
    Coef_WE  = 1'b0;
  endtask

  task automatic wcoef(input int unsigned addr, input int unsigned data);
    wait_ready();
    Coef_WE   = 1'b1;
    Coef_Addr = 4'(addr);
    Coef_Data = 8'(data);
    @(posedge clk);
    m_coef[addr] = data;
    #1;
    Coef_WE = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    In_Valid = 1'b0;
    Coef_WE  = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", In_Ready, 1);
    check("rst_out_valid", Out_Valid, 0);
    check("rst_out_filtered", Out_Filtered, 0);
    check("rst_out_channel", Out_Channel, 0);
  endtask

  initial begin
    model_reset();
    do_reset();

    // A single sample with the unit coefficients returns the sample.
    send(0, 200);
    drain();
    check("single_200", Out_Filtered, 200);
    check("single_ch", Out_Channel, 0);

    // Filling the history, then replacing it, back to back.
    do_reset();
    for (int i = 0; i < 16; i++) send(0, 200);
    check("throughput", last_acc_t - prev_acc_t, (TAPS + 2) * P);
    drain();
    check("fill_3200", Out_Filtered, 3200);
    for (int i = 0; i < 16; i++) send(0, 100);
    drain();
    check("refill_1600", Out_Filtered, 1600);

    // The channels are independent.
    do_reset();
    send(0, 200);
    send(1, 100);
    drain();
    check("ch1_first", Out_Filtered, 100);
    check("ch1_chan", Out_Channel, 1);
    send(0, 200);
    drain();
    check("ch0_second", Out_Filtered, 400);

    // Coefficient extremes.
    do_reset();
    wcoef(0, 255);
    for (int k = 1; k < TAPS; k++) wcoef(k, 0);
    send(0, 255);
    drain();
    check("coef0_255", Out_Filtered, 65025);
    for (int k = 0; k < TAPS; k++) wcoef(k, 255);
    for (int i = 0; i < 16; i++) send(0, 255);
    drain();
    check("full_scale", Out_Filtered, 1040400);

    // A reset in mid-MAC aborts the result and restores the default state.
    send(0, 50);
    repeat (5) @(negedge clk);
    do_reset();
    repeat (TAPS + 4) @(negedge clk);
    check("abort_no_output", Out_Valid, 0);
    send(0, 100);
    drain();
    check("after_abort", Out_Filtered, 100);

    // An out-of-range channel is accepted and dropped.
    send(3, 123);
    @(negedge clk);
    check("bad_ch_ready", In_Ready, 1);
    repeat (TAPS + 4) @(negedge clk);
    check("bad_ch_no_out", Out_Filtered, 100);

    // Sample and coefficient inputs are ignored while busy.
    send(2, 10);
    @(negedge clk);
    In_Valid = 1'b1; In_Channel = 2'd2; In_Sample = 8'd99;
    Coef_WE = 1'b1; Coef_Addr = 4'd0; Coef_Data = 8'd7;
    repeat (3) @(negedge clk);
    In_Valid = 1'b0; Coef_WE = 1'b0;
    drain();
    check("busy_ignored", Out_Filtered, 10);

    // A coefficient write and a sample on the same cycle both take effect.
    send(2, 20, 1, 0, 5);
    drain();
    check("same_cycle_coef", Out_Filtered, 110);

`ifdef FIR_BYPASS_EN
    do_reset();
    bypass = 1'b1;
    send(0, 77);
    drain();
    check("bypass_77", Out_Filtered, 77);
    bypass = 1'b0;
    send(0, 0);
    drain();
    check("bypass_hist", Out_Filtered, 77);
`endif

    // Randomized coefficients, channels and samples.
    do_reset();
    for (int k = 0; k < TAPS; k++) wcoef(k, $urandom_range(0, 255));
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0)
        send($urandom_range(0, 3), $urandom_range(0, 255), 1,
             $urandom_range(0, TAPS - 1), $urandom_range(0, 255));
      else
        send($urandom_range(0, 3), $urandom_range(0, 255));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
